spi_master_frame: RTL

Single-clock SPI mode-0 master. Shifts out one `width`-bit frame on `mosi` while capturing `width` bits from `miso`, framed by an active-low chip select. Drives the SPI peripherals on the interconnect, including our address-latching slave, from a simple start/done handshake.

---
 rtl/spi_master_frame.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_frame.sv
// -----------------------------------------------------------------------------
// spi_master_frame
//
// Single-clock SPI mode-0 master. One start request shifts a width-bit frame
// out on mosi while capturing width bits from miso, framed by an active-low
// chip select. sclk idles low; miso is sampled on rising sclk and mosi
// changes on falling sclk.
//
// Build option:
//   SPI_MASTER_LSB_FIRST_EN  defined   -> txData[0] goes out first, the first
//                                         received bit lands in rxData[0].
//                            undefined -> MSB first (default).
//   Timing is identical in both builds.
//
// Parameters:
//   width       frame length in bits (>= 2)
//   halfPeriod  sclk half period in clk cycles (>= 1)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   start      in   frame request
//   txData     in   frame to send, captured when start is accepted
//   busy       out  high whenever the controller is not idle
//   done       out  one-cycle pulse when rxData is updated
//   rxData     out  last received frame, held until the next done
//   sclk       out  SPI clock, idles low
//   cs         out  chip select, active low, idles high
//   mosi       out  serial data out
//   miso       in   serial data in, already synchronous to clk
//   dbg_state  out  current controller state (state_t encoding)
//
// Handshake: start is accepted on a rising clk edge where busy is low; the
// same edge captures txData. start seen while busy is high is dropped (no
// queueing). done pulses high for exactly one cycle at the edge that updates
// rxData and drops busy, so a start held high during that done cycle is
// accepted and launches the next frame with cs high for a single cycle.
//
// All outputs come straight from flops; nothing combinational reaches an
// output from an input.
// -----------------------------------------------------------------------------
module spi_master_frame #(
  parameter int width      = 8,
  parameter int halfPeriod = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [width-1:0] txData,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] rxData,
  output logic             sclk,
  output logic             cs,
  output logic             mosi,
  input  logic             miso,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  // A one-bit timer is kept even for halfPeriod == 1 so the vector is legal;
  // in that case it simply stays at zero and expires every cycle.
  localparam int TW = (halfPeriod > 1) ? $clog2(halfPeriod) : 1;
  localparam int CW = $clog2(width + 1);

  localparam logic [TW-1:0] T_LAST = TW'(halfPeriod - 1);
  localparam logic [CW-1:0] C_LAST = CW'(width - 1);

  state_t              state_q,    state_d;
  logic [TW-1:0]       timer_q,    timer_d;
  logic [CW-1:0]       bit_cnt_q,  bit_cnt_d;
  logic [width-1:0]    tx_shift_q, tx_shift_d;
  logic [width-1:0]    rx_shift_q, rx_shift_d;
  logic [width-1:0]    rx_data_q,  rx_data_d;
  logic                busy_q,     busy_d;
  logic                done_q,     done_d;
  logic                sclk_q,     sclk_d;
  logic                cs_q,       cs_d;
  logic                mosi_q,     mosi_d;

  logic                timer_expired;

  // Bit-order dependent helpers. tx_next_shift/tx_next_bit describe the tx
  // register after one falling-edge shift and the bit that then appears on
  // mosi; rx_next_shift is the rx register after capturing miso.
  logic                tx_first_bit;
  logic [width-1:0]    tx_next_shift;
  logic                tx_next_bit;
  logic [width-1:0]    rx_next_shift;

`ifdef SPI_MASTER_LSB_FIRST_EN
  always_comb begin
    tx_first_bit  = txData[0];
    tx_next_shift = {1'b0, tx_shift_q[width-1:1]};
    tx_next_bit   = tx_shift_q[1];
    rx_next_shift = {miso, rx_shift_q[width-1:1]};
  end
`else
  always_comb begin
    tx_first_bit  = txData[width-1];
    tx_next_shift = {tx_shift_q[width-2:0], 1'b0};
    tx_next_bit   = tx_shift_q[width-2];
    rx_next_shift = {rx_shift_q[width-2:0], miso};
  end
`endif

  assign timer_expired = (timer_q == T_LAST);

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    sclk_d     = sclk_q;
    cs_d       = cs_q;
    mosi_d     = mosi_q;
    // done is a pulse: it falls back to zero unless HOLD expires this cycle.
    done_d     = 1'b0;

    // The half-period timer runs in every non-idle state and wraps on expiry,
    // so each state lasts exactly halfPeriod cycles.
    if (state_q == S_IDLE) begin
      timer_d = '0;
    end else if (timer_expired) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          tx_shift_d = txData;
          cs_d       = 1'b0;
          mosi_d     = tx_first_bit;
          bit_cnt_d  = '0;
          state_d    = S_SETUP;
        end
      end

      S_SETUP: begin
        if (timer_expired) begin
          sclk_d     = 1'b1;
          rx_shift_d = rx_next_shift;
          state_d    = S_HIGH;
        end
      end

      S_HIGH: begin
        if (timer_expired) begin
          sclk_d    = 1'b0;
          bit_cnt_d = bit_cnt_q + 1'b1;
          // Comparing the pre-increment count against width-1 is the same
          // as the incremented count reaching width.
          if (bit_cnt_q == C_LAST) begin
            state_d = S_HOLD;
          end else begin
            tx_shift_d = tx_next_shift;
            mosi_d     = tx_next_bit;
            state_d    = S_LOW;
          end
        end
      end

      S_LOW: begin
        if (timer_expired) begin
          sclk_d     = 1'b1;
          rx_shift_d = rx_next_shift;
          state_d    = S_HIGH;
        end
      end

      S_HOLD: begin
        if (timer_expired) begin
          cs_d      = 1'b1;
          mosi_d    = 1'b0;
          rx_data_d = rx_shift_q;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // busy is registered from the next state so it rises with cs and falls
    // on the same edge as done.
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers. Reset is asynchronous so cs rises and the
  // partial frame is dropped without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
      cs_q       <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sclk_q     <= sclk_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rxData    = rx_data_q;
  assign sclk      = sclk_q;
  assign cs        = cs_q;
  assign mosi      = mosi_q;
  assign dbg_state = state_q;

endmodule
